uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART transmit block.
//   parity_mode_e : encoding of the parity_mode configuration input
//   tx_state_e    : transmit FSM states
//   clamp_bits()  : limits a requested data-bit count to 5..max_bits
//   frame_parity(): parity bit for the low nbits of a word
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_W    = 9;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req,
                                            input logic [3:0] max_bits);
    logic [3:0] res;
    res = req;
    if (req < 4'(MIN_DATA_BITS)) res = 4'(MIN_DATA_BITS);
    else if (req > max_bits)     res = max_bits;
    return res;
  endfunction

  // Even parity is the XOR of the transmitted bits; odd is its inverse.
  function automatic logic frame_parity(input logic [MAX_DATA_W-1:0] data,
                                        input logic [3:0]            nbits,
                                        input parity_mode_e          mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (4'(i) < nbits) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead FIFO feeding the transmitter.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i    : write data_i (ignored while full, even with a pop)
//   pop_i     : drop the head entry (ignored while empty)
//   data_o    : current head entry, valid whenever empty_o is low
//   full_o, empty_o, level_o : occupancy status
module uart_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == LVL_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO.
//   clk, rst          : clock, asynchronous active-high reset (aborts any frame)
//   tx_en             : allows new frames to start
//   n_data_bits, parity_mode, n_stop_bits, clk_divider : frame format,
//                       sampled when a word is popped for transmission
//   in_dat_i/in_vld_i/in_rdy_o : write side of the FIFO
//   tx_o              : serial line (idle high)
//   busy_o            : a frame is on the line
//   fifo_level_o      : FIFO occupancy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic [3:0]                    n_data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          n_stop_bits,
  input  logic [DIV_W-1:0]              clk_divider,
  input  logic [DATA_W-1:0]             in_dat_i,
  input  logic                          in_vld_i,
  output logic                          in_rdy_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  logic [DATA_W-1:0]     fifo_data;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [MAX_DATA_W-1:0] data_ext;
  parity_mode_e          mode_in;

  tx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            bits_left_q, bits_left_d;
  logic                  stop_extra_q, stop_extra_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done, start_frame;

  uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_vld_i),
    .data_i  (in_dat_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign in_rdy_o = !fifo_full;
  assign tx_o     = tx_q;
  assign busy_o   = busy_q;
  assign mode_in  = parity_mode_e'(parity_mode);
  assign bit_done = (cnt_q == '0);

  always_comb begin
    data_ext               = '0;
    data_ext[DATA_W-1:0]   = fifo_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bits_left_d  = bits_left_q;
    stop_extra_d = stop_extra_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    shift_d      = shift_q;
    start_frame  = 1'b0;

    // cnt_q counts down the remaining cycles of the current bit period.
    if (state_q != ST_IDLE) begin
      cnt_d = bit_done ? div_q : cnt_q - DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bits_left_q == 4'd1) state_d = par_en_q ? ST_PARITY : ST_STOP;
          else                     bits_left_d = bits_left_q - 4'd1;
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_extra_q)                stop_extra_d = 1'b0;
          else if (tx_en && !fifo_empty)   start_frame  = 1'b1;
          else                             state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame format is captured together with the word so that input
    // changes during a frame only affect later frames.
    if (start_frame) begin
      state_d      = ST_START;
      cnt_d        = clk_divider;
      div_d        = clk_divider;
      shift_d      = fifo_data;
      bits_left_d  = clamp_bits(n_data_bits, 4'(DATA_W));
      stop_extra_d = n_stop_bits;
      par_en_d     = (mode_in == PAR_EVEN) || (mode_in == PAR_ODD);
      par_bit_d    = frame_parity(data_ext, bits_left_d, mode_in);
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign fifo_pop = start_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      bits_left_q  <= '0;
      stop_extra_q <= 1'b0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bits_left_q  <= bits_left_d;
      stop_extra_q <= stop_extra_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

endmodule
